ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram16x4.sv | 34 +++
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the two-port RAM arbiter: default RAM geometry
//   and the arbiter FSM state encoding.
//   Contents:
//     ADDR_W_DEF  default address width (16 words)
//     DATA_W_DEF  default word width
//     state_e     IDLE / GNT_A / GNT_B
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

endpackage

// File: rtl/ram16x4.sv
// ram16x4
//   Single-port storage array: synchronous write, asynchronous read.
//   Ports:
//     clk   in   write clock
//     wen   in   write enable; din is stored at addr on the rising edge
//     addr  in   word address (shared by read and write)
//     din   in   write data
//     qout  out  combinational read data, mem[addr]
module ram16x4
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] qout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset on purpose; contents survive rst and a
    // reset loop over every word would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= din;
        end
    end

    assign qout = mem[addr];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Round-robin arbiter giving two requesters (A, B) serialised access to
//   one RAM. A grant lasts one cycle; the granted port's command is latched
//   on the grant edge, executed during the GNT cycle, and acknowledged with
//   a one-cycle pulse in the following cycle.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_x, wen_x, addr_x, din_x port x request, write enable, address, data
//     gnt_x                       port x owns the RAM this cycle
//     ack_x                       port x access completed (one-cycle pulse)
//     qout                        read data, valid in the ack cycle of a read
//     busy                        arbiter not idle
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              wen_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              req_b,
    input  logic              wen_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] qout,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DATA_W-1:0] qout_q, qout_d;
    logic              lat_wen_q, lat_wen_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_din_q, lat_din_d;

    logic              elig_a, elig_b;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        // A port is not eligible while it is being served or acknowledged,
        // so a request still high in its ack cycle is never served twice.
        elig_a = req_a && !ack_a_q && (state_q != GNT_A);
        elig_b = req_b && !ack_b_q && (state_q != GNT_B);

        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (elig_a && elig_b) begin
                    state_d = last_b_q ? GNT_A : GNT_B;
                end else if (elig_a) begin
                    state_d = GNT_A;
                end else if (elig_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (elig_b) begin
                    state_d = GNT_B;
                end else if (elig_a) begin
                    state_d = GNT_A;
                end
            end
            GNT_B: begin
                if (elig_a) begin
                    state_d = GNT_A;
                end else if (elig_b) begin
                    state_d = GNT_B;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Command latch, round-robin pointer, ack and read data
    // ---------------------------------------------------------------
    always_comb begin
        last_b_d   = last_b_q;
        lat_wen_d  = lat_wen_q;
        lat_addr_d = lat_addr_q;
        lat_din_d  = lat_din_q;

        // Entering a GNT state is the grant edge: capture that port's command.
        case (state_d)
            GNT_A: begin
                last_b_d   = 1'b0;
                lat_wen_d  = wen_a;
                lat_addr_d = addr_a;
                lat_din_d  = din_a;
            end
            GNT_B: begin
                last_b_d   = 1'b1;
                lat_wen_d  = wen_b;
                lat_addr_d = addr_b;
                lat_din_d  = din_b;
            end
            default: ;
        endcase

        ack_a_d = (state_q == GNT_A);
        ack_b_d = (state_q == GNT_B);

        // A reset arriving in a GNT cycle must stop the write from committing.
        ram_wen = (state_q != IDLE) && lat_wen_q && !rst;

        qout_d = qout_q;
        if ((state_q != IDLE) && !lat_wen_q) begin
            qout_d = ram_rdata;
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, with the
    // synchronous reset taking priority inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            qout_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            qout_q   <= qout_d;
        end
    end

    // The command latch is only consumed in GNT states, which are always
    // preceded by a load, so it carries no reset.
    always_ff @(posedge clk) begin
        lat_wen_q  <= lat_wen_d;
        lat_addr_q <= lat_addr_d;
        lat_din_q  <= lat_din_d;
    end

    ram16x4 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk  (clk),
        .wen  (ram_wen),
        .addr (lat_addr_q),
        .din  (lat_din_q),
        .qout (ram_rdata)
    );

    assign gnt_a = (state_q == GNT_A);
    assign gnt_b = (state_q == GNT_B);
    assign busy  = (state_q != IDLE);
    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign qout  = qout_q;

endmodule
